// File: rtl/mlp_accum_sched.sv
// Issue scheduler for the MLP accumulator: walks N_HIDDEN neurons x CHUNKS operand chunks, then one layer-2 drain issue.
// Latency N_HIDDEN*CHUNKS+1 issues plus done; stalls (no-op mode 10 / p_zero) on op_valid_i low or missing l2_valid_i.
module mlp_accum_sched #(
    parameter int N_HIDDEN = 32,
    parameter int CHUNKS   = 8,
    parameter int NW       = 6,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          op_valid_i,
    output logic          op_ready_o,
    input  logic          l2_valid_i,
    output logic          l2_ack_o,
    output logic [1:0]    mode_o,
    output logic          p_zero_o,
    output logic [NW-1:0] neuron_idx_o,
    output logic [CW-1:0] chunk_idx_o,
    output logic          act_capture_o,
    output logic [NW-1:0] act_idx_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] LAST_CHUNK  = CW'(CHUNKS - 1);
    localparam logic [NW-1:0] LAST_NEURON = NW'(N_HIDDEN - 1);

    state_t        state_q;
    logic [NW-1:0] neuron_q;
    logic [CW-1:0] chunk_q;
    logic          cap_q;
    logic [NW-1:0] aidx_q;
    logic          busy_q;
    logic          done_q;

    logic last_chunk_d;
    logic need_l2_d;
    logic issue_d;
    logic drain_fire_d;

    // The last chunk of any neuron after the first also folds in the previous neuron's L2 products.
    assign last_chunk_d = (chunk_q == LAST_CHUNK);
    assign need_l2_d    = last_chunk_d && (neuron_q != '0);
    assign op_ready_o   = (state_q == S_RUN) && (!need_l2_d || l2_valid_i);
    assign issue_d      = op_valid_i && op_ready_o;
    assign drain_fire_d = (state_q == S_DRAIN) && l2_valid_i;

    always_comb begin
        mode_o   = 2'b10;
        p_zero_o = 1'b1;
        l2_ack_o = 1'b0;
        if (issue_d) begin
            p_zero_o = 1'b0;
            if (chunk_q == '0) begin
                mode_o = (neuron_q == '0) ? 2'b00 : 2'b01;
            end else if (need_l2_d) begin
                mode_o   = 2'b11;
                l2_ack_o = 1'b1;
            end
        end else if (drain_fire_d) begin
            mode_o   = 2'b11;
            l2_ack_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            neuron_q <= '0;
            chunk_q  <= '0;
            cap_q    <= 1'b0;
            aidx_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Accumulator output registers one cycle after the last-chunk issue.
            cap_q  <= issue_d && last_chunk_d;
            done_q <= 1'b0;
            if (issue_d && last_chunk_d) begin
                aidx_q <= neuron_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q  <= S_RUN;
                        neuron_q <= '0;
                        chunk_q  <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue_d) begin
                        if (last_chunk_d) begin
                            chunk_q <= '0;
                            if (neuron_q == LAST_NEURON) begin
                                state_q <= S_DRAIN;
                            end else begin
                                neuron_q <= neuron_q + NW'(1);
                            end
                        end else begin
                            chunk_q <= chunk_q + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (l2_valid_i) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign neuron_idx_o  = neuron_q;
    assign chunk_idx_o   = chunk_q;
    assign act_capture_o = cap_q;
    assign act_idx_o     = aidx_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_mlp_accum_sched.sv
// Directed bench: u0 is a 3-neuron x 4-chunk scheduler, u1 a 1-neuron x 2-chunk one.
module tb_mlp_accum_sched;

    logic clk;
    logic rst;
    logic start0, start1;
    logic op_valid, l2_valid;

    logic       rdy0, ack0, pz0, cap0, bsy0, dn0;
    logic [1:0] md0;
    logic [5:0] n0, ai0;
    logic [2:0] c0;
    logic       rdy1, ack1, pz1, cap1, bsy1, dn1;
    logic [1:0] md1;
    logic [5:0] n1, ai1;
    logic [2:0] c1;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mlp_accum_sched #(.N_HIDDEN(3), .CHUNKS(4), .NW(6), .CW(3)) u0 (
        .clk(clk), .rst(rst), .start_i(start0), .op_valid_i(op_valid), .op_ready_o(rdy0),
        .l2_valid_i(l2_valid), .l2_ack_o(ack0), .mode_o(md0), .p_zero_o(pz0),
        .neuron_idx_o(n0), .chunk_idx_o(c0), .act_capture_o(cap0), .act_idx_o(ai0),
        .busy_o(bsy0), .done_o(dn0)
    );

    mlp_accum_sched #(.N_HIDDEN(1), .CHUNKS(2), .NW(6), .CW(3)) u1 (
        .clk(clk), .rst(rst), .start_i(start1), .op_valid_i(op_valid), .op_ready_o(rdy1),
        .l2_valid_i(l2_valid), .l2_ack_o(ack1), .mode_o(md1), .p_zero_o(pz1),
        .neuron_idx_o(n1), .chunk_idx_o(c1), .act_capture_o(cap1), .act_idx_o(ai1),
        .busy_o(bsy1), .done_o(dn1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout printed on a miss: {rdy,mode[1:0],p_zero,l2_ack,act_capture,busy,done, neuron, chunk, act_idx}
    typedef struct packed {
        logic       rdy;
        logic [1:0] md;
        logic       pz;
        logic       ack;
        logic       cap;
        logic       bsy;
        logic       dn;
        logic       ix;
        logic [7:0] n;
        logic [7:0] c;
        logic [7:0] ai;
    } row_t;

    row_t nom [16];

    function automatic row_t R(input int rdy, input int md, input int pz, input int ack, input int n,
                               input int c, input int cap, input int ai, input int bsy, input int dn);
        row_t r;
        r.rdy = 1'(rdy);
        r.md  = 2'(md);
        r.pz  = 1'(pz);
        r.ack = 1'(ack);
        r.cap = 1'(cap);
        r.bsy = 1'(bsy);
        r.dn  = 1'(dn);
        r.ix  = (n >= 0);
        r.n   = r.ix ? 8'(n) : 8'h0;
        r.c   = r.ix ? 8'(c) : 8'h0;
        r.ai  = r.cap ? 8'(ai) : 8'h0;
        return r;
    endfunction

    // Inputs are driven 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic ex(input string tag, input int sel, input row_t r);
        logic       o_rdy, o_pz, o_ack, o_cap, o_bsy, o_dn;
        logic [1:0] o_md;
        logic [5:0] o_n, o_ai;
        logic [2:0] o_c;
        logic [31:0] obs, exp_v;
        #1;
        if (sel == 0) begin
            o_rdy = rdy0; o_md = md0; o_pz = pz0; o_ack = ack0; o_cap = cap0;
            o_bsy = bsy0; o_dn = dn0; o_n = n0; o_c = c0; o_ai = ai0;
        end else begin
            o_rdy = rdy1; o_md = md1; o_pz = pz1; o_ack = ack1; o_cap = cap1;
            o_bsy = bsy1; o_dn = dn1; o_n = n1; o_c = c1; o_ai = ai1;
        end
        obs = {o_rdy, o_md, o_pz, o_ack, o_cap, o_bsy, o_dn,
               r.ix ? {2'b00, o_n} : 8'h00,
               r.ix ? {5'b00000, o_c} : 8'h00,
               r.cap ? {2'b00, o_ai} : 8'h00};
        exp_v = {r.rdy, r.md, r.pz, r.ack, r.cap, r.bsy, r.dn, r.n, r.c, r.ai};
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s cyc %0d: observed %h expected %h", tag, cyc, obs, exp_v);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Walks rows from..to of the uninterrupted u0 inference; optional busy start pulse / held start, optional reset.
    task automatic nominal(input string tag, input int bump, input int rst_at, input int from, input int to);
        if (from == 0) cyc = 0;
        for (int k = from; k <= to; k++) begin
            start0 = (k == 0) || ((bump != 0) && (k == 2 || k >= 13));
            rst    = (k == rst_at);
            ex(tag, 0, nom[k]);
            if (k == rst_at) begin
                rst    = 1'b0;
                start0 = 1'b0;
                return;
            end
        end
        if (bump == 0) start0 = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start0   = 1'b0;
        start1   = 1'b0;
        op_valid = 1'b1;
        l2_valid = 1'b1;

        nom[0]  = R(0, 2'b10, 1, 0, -1, -1, 0, 0, 0, 0);
        nom[1]  = R(1, 2'b00, 0, 0,  0,  0, 0, 0, 1, 0);
        nom[2]  = R(1, 2'b10, 0, 0,  0,  1, 0, 0, 1, 0);
        nom[3]  = R(1, 2'b10, 0, 0,  0,  2, 0, 0, 1, 0);
        nom[4]  = R(1, 2'b10, 0, 0,  0,  3, 0, 0, 1, 0);
        nom[5]  = R(1, 2'b01, 0, 0,  1,  0, 1, 0, 1, 0);
        nom[6]  = R(1, 2'b10, 0, 0,  1,  1, 0, 0, 1, 0);
        nom[7]  = R(1, 2'b10, 0, 0,  1,  2, 0, 0, 1, 0);
        nom[8]  = R(1, 2'b11, 0, 1,  1,  3, 0, 0, 1, 0);
        nom[9]  = R(1, 2'b01, 0, 0,  2,  0, 1, 1, 1, 0);
        nom[10] = R(1, 2'b10, 0, 0,  2,  1, 0, 0, 1, 0);
        nom[11] = R(1, 2'b10, 0, 0,  2,  2, 0, 0, 1, 0);
        nom[12] = R(1, 2'b11, 0, 1,  2,  3, 0, 0, 1, 0);
        nom[13] = R(0, 2'b11, 1, 1, -1, -1, 1, 2, 1, 0);
        nom[14] = R(0, 2'b10, 1, 0, -1, -1, 0, 0, 1, 1);
        nom[15] = R(0, 2'b10, 1, 0, -1, -1, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        ex("RST_u0", 0, R(0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
        ex("RST_u1", 1, R(0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        ex("IDLE", 0, R(0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));

        // T1: no stalls
        nominal("T1", 0, -1, 0, 15);

        // T2: two op_valid-low cycles at neuron 1 chunk 2
        nominal("T2", 0, -1, 0, 6);
        op_valid = 1'b0;
        ex("T2_stall", 0, R(1, 2'b10, 1, 0, 1, 2, 0, 0, 1, 0));
        ex("T2_stall", 0, R(1, 2'b10, 1, 0, 1, 2, 0, 0, 1, 0));
        op_valid = 1'b1;
        nominal("T2", 0, -1, 7, 15);

        // T3: l2_valid absent until 3 cycles after neuron 1 chunk 2 issues
        l2_valid = 1'b0;
        nominal("T3", 0, -1, 0, 7);
        ex("T3_l2wait", 0, R(0, 2'b10, 1, 0, 1, 3, 0, 0, 1, 0));
        ex("T3_l2wait", 0, R(0, 2'b10, 1, 0, 1, 3, 0, 0, 1, 0));
        ex("T3_l2wait", 0, R(0, 2'b10, 1, 0, 1, 3, 0, 0, 1, 0));
        l2_valid = 1'b1;
        nominal("T3", 0, -1, 8, 15);

        // T4: reset at neuron 2 chunk 1, then a fresh inference
        nominal("T4", 0, 10, 0, 15);
        ex("T4_rst", 0, R(0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
        ex("T4_rst", 0, R(0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
        nominal("T4_again", 0, -1, 0, 15);

        // Reset on a last-chunk issue drops the pending act_capture
        nominal("T4b", 0, 4, 0, 15);
        ex("T4b_rst", 0, R(0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));

        // T5: start pulsed while busy, then held across drain/done/idle
        nominal("T5", 1, -1, 0, 15);
        nominal("T5_held", 0, -1, 1, 15);

        // T6: single neuron, two chunks
        cyc    = 0;
        start1 = 1'b1;
        ex("T6", 1, R(0, 2'b10, 1, 0, -1, -1, 0, 0, 0, 0));
        start1 = 1'b0;
        ex("T6", 1, R(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0));
        ex("T6", 1, R(1, 2'b10, 0, 0, 0, 1, 0, 0, 1, 0));
        ex("T6", 1, R(0, 2'b11, 1, 1, -1, -1, 1, 0, 1, 0));
        ex("T6", 1, R(0, 2'b10, 1, 0, -1, -1, 0, 0, 1, 1));
        ex("T6", 1, R(0, 2'b10, 1, 0, -1, -1, 0, 0, 0, 0));

        // T6 with drain waiting a cycle for l2_valid
        cyc      = 0;
        l2_valid = 1'b0;
        start1   = 1'b1;
        ex("T6w", 1, R(0, 2'b10, 1, 0, -1, -1, 0, 0, 0, 0));
        start1 = 1'b0;
        ex("T6w", 1, R(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0));
        ex("T6w", 1, R(1, 2'b10, 0, 0, 0, 1, 0, 0, 1, 0));
        ex("T6w", 1, R(0, 2'b10, 1, 0, -1, -1, 1, 0, 1, 0));
        l2_valid = 1'b1;
        ex("T6w", 1, R(0, 2'b11, 1, 1, -1, -1, 0, 0, 1, 0));
        ex("T6w", 1, R(0, 2'b10, 1, 0, -1, -1, 0, 0, 1, 1));
        ex("T6w", 1, R(0, 2'b10, 1, 0, -1, -1, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
